// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//
// Purpose:
//   Serial receiver for the Basys3 USB-UART bridge line. Turns an
//   asynchronous serial stream into parallel bytes for the downstream
//   byte-to-bit LED splitter. The last correctly framed byte is held on
//   o_byte. One-cycle strobes mark a good byte or a framing error.
//
//   Default frame: 8N1 (start, 8 data bits LSB first, stop).
//   Optional macro UART_RX_PARITY_EN: when it is defined the frame becomes
//   8E1. An even-parity bit sits between the data bits and the stop bit.
//   A parity mismatch is reported as a framing error.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535), default 868
//                 (100 MHz / 115200 baud)
//   SYNC_STAGES   synchroniser depth on i_rx (2..4), default 2
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx         raw serial line, idles high, asynchronous to i_clk
//   o_byte       last correctly framed byte, bit 0 = first data bit
//   o_valid      one-cycle pulse when o_byte is updated
//   o_frame_err  one-cycle pulse on a bad stop bit (or bad parity)
//   o_busy       high from start-bit detection until return to IDLE
// ---------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);

  // The timer restarts at zero on the edge that enters a state. It therefore
  // reaches (N-1) on the N-th edge spent in that state.
  localparam logic [TIMER_W-1:0] MID_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;
`endif

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  // Bring the asynchronous line into the clock domain. The flops reset to 1,
  // which is the idle level of the line. A line held low during reset then
  // cannot look like a start bit the moment reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Receive FSM with registered outputs.
  //
  // The start bit is re-checked at its middle, so short low glitches are
  // rejected. Every later bit is sampled one full bit period after the
  // previous sample, which keeps all samples at mid-bit.
  //
  // The strobes default low every cycle, so each one lasts exactly one
  // cycle. They are set on the mid-stop sample edge. Valid and error are
  // set in exclusive branches, so they can never be high together.
  //
  // After a bad stop bit the FSM parks in WAIT_IDLE until the line goes
  // high again. A held break therefore reports one error, not a stream of
  // them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_byte      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            timer  <= '0;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (timer == MID_LAST) begin
            timer <= '0;
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer     <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit makes the count of ones across the
        // data bits and the parity bit even.
        PARITY: begin
          if (timer == BIT_LAST) begin
            timer      <= '0;
            parity_err <= rx_s ^ (^shift_reg);
            state      <= STOP;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
`endif

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
`ifdef UART_RX_PARITY_EN
            if (rx_s && !parity_err) begin
`else
            if (rx_s) begin
`endif
              o_byte  <= shift_reg;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
              state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          timer  <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//
// Purpose:
//   Drives serial frames into uart_rx_byte (CLKS_PER_BIT=16, SYNC_STAGES=2).
//   The expected byte and strobe timing of each frame are worked out from
//   the frame format alone. The bench checks reset, single and back-to-back
//   frames, glitch rejection, framing error with break, a mid-frame reset
//   and a batch of random bytes. With UART_RX_PARITY_EN it also checks
//   parity.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_POS = 10;
`else
  localparam int STOP_POS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         valid_cyc_q[$];
  logic [7:0] valid_byte_q[$];
  int         err_cyc_q[$];
  int         both_cnt = 0;
  int         bad_change = 0;
  int         busy_drops = 0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] model_byte = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_byte     (data_out),
    .o_valid    (valid),
    .o_frame_err(frame_err),
    .o_busy     (busy)
  );

  // 100 MHz clock and a free-running cycle count
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe on the falling edge, away from the active edge.
  // Also watch for any o_byte change that is not tied to o_valid.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cyc_q.push_back(cyc);
      valid_byte_q.push_back(data_out);
    end
    if (frame_err === 1'b1) err_cyc_q.push_back(cyc);
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (rst_n && valid !== 1'b1 && data_out !== prev_byte) bad_change++;
    prev_byte = data_out;
  end

  // The strobe lands one cycle after the mid-stop sample. Counted from the
  // cycle the start bit is driven, that is: the synchroniser delay, one edge
  // for IDLE to see the low line, half a bit to mid-start, then STOP_POS
  // whole bits to mid-stop.
  function automatic int exp_strobe_cyc(input int start_cyc);
    return start_cyc + SYNC + 1 + CPB / 2 + STOP_POS * CPB;
  endfunction

  function automatic int q_int(input int idx, input int which);
    if (which == 0) return (idx < valid_cyc_q.size()) ? valid_cyc_q[idx] : -1;
    if (which == 1) return (idx < valid_byte_q.size()) ? int'(valid_byte_q[idx]) : -1;
    return (idx < err_cyc_q.size()) ? err_cyc_q[idx] : -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    valid_cyc_q.delete();
    valid_byte_q.delete();
    err_cyc_q.delete();
    busy_drops = 0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame, starting in the current cycle. It always ends 1 ns
  // after a rising edge, so frames can be chained without a gap.
  // o_busy is sampled at the end of every bit before the stop bit.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    if (busy !== 1'b1) busy_drops++;
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i]);
      if (busy !== 1'b1) busy_drops++;
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_flip);
    if (busy !== 1'b1) busy_drops++;
`endif
    drive_bit(stop);
  endtask

  initial begin : main
    int s0;
    int s1;
    int exp_cyc_q[$];
    logic [7:0] exp_byte_q[$];
    int exp_err_q[$];
    logic [7:0] d;
    logic good;
    int gap;

    $display("[TB] start");

    // Reset with the line low; release only after the line is high
    rx = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("reset_byte", data_out, 8'h00);
    check_output("reset_valid", valid, 1'b0);
    check_output("reset_frame_err", frame_err, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    repeat (200) @(posedge clk);
    #1;
    check_output("post_reset_no_valid", valid_cyc_q.size(), 0);
    check_output("post_reset_no_err", err_cyc_q.size(), 0);
    check_output("post_reset_busy", busy, 1'b0);
    check_output("post_reset_byte", data_out, 8'h00);

    // Single byte 0xA5
    clear_log();
    apply_stimulus(8'hA5, 1'b1, s0);
    model_byte = 8'hA5;
    idle(4);
    check_output("a5_valid_count", valid_cyc_q.size(), 1);
    check_output("a5_valid_cycle", q_int(0, 0), exp_strobe_cyc(s0));
    check_output("a5_valid_byte", q_int(0, 1), 32'hA5);
    check_output("a5_byte_held", data_out, model_byte);
    check_output("a5_busy_during", busy_drops, 0);
    check_output("a5_busy_after", busy, 1'b0);
    check_output("a5_no_err", err_cyc_q.size(), 0);

    // Back-to-back 0x00 then 0xFF with no idle gap
    clear_log();
    apply_stimulus(8'h00, 1'b1, s0);
    apply_stimulus(8'hFF, 1'b1, s1);
    model_byte = 8'hFF;
    idle(4);
    check_output("b2b_valid_count", valid_cyc_q.size(), 2);
    check_output("b2b_first_byte", q_int(0, 1), 32'h00);
    check_output("b2b_second_byte", q_int(1, 1), 32'hFF);
    check_output("b2b_first_cycle", q_int(0, 0), exp_strobe_cyc(s0));
    check_output("b2b_second_cycle", q_int(1, 0), exp_strobe_cyc(s1));
    check_output("b2b_no_err", err_cyc_q.size(), 0);

    // Glitch: line low for only 4 cycles
    clear_log();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("glitch_busy_high", busy, 1'b1);
    idle(40);
    check_output("glitch_busy_low", busy, 1'b0);
    check_output("glitch_no_valid", valid_cyc_q.size(), 0);
    check_output("glitch_no_err", err_cyc_q.size(), 0);
    check_output("glitch_byte_kept", data_out, model_byte);

    // Framing error 0x3C with a low stop bit, line held low, then 0x12
    clear_log();
    apply_stimulus(8'h3C, 1'b0, s0);
    repeat (40) @(posedge clk);
    #1;
    check_output("ferr_byte_during_break", data_out, model_byte);
    check_output("ferr_busy_during_break", busy, 1'b1);
    idle(20);
    check_output("ferr_err_count", err_cyc_q.size(), 1);
    check_output("ferr_err_cycle", q_int(0, 2), exp_strobe_cyc(s0));
    check_output("ferr_no_valid", valid_cyc_q.size(), 0);
    check_output("ferr_busy_after", busy, 1'b0);
    clear_log();
    apply_stimulus(8'h12, 1'b1, s0);
    model_byte = 8'h12;
    idle(4);
    check_output("after_ferr_valid_count", valid_cyc_q.size(), 1);
    check_output("after_ferr_byte", q_int(0, 1), 32'h12);
    check_output("after_ferr_cycle", q_int(0, 0), exp_strobe_cyc(s0));

`ifdef UART_RX_PARITY_EN
    // 0x07 with the correct parity bit, then with the wrong one
    clear_log();
    par_flip = 1'b0;
    apply_stimulus(8'h07, 1'b1, s0);
    model_byte = 8'h07;
    idle(4);
    par_flip = 1'b1;
    apply_stimulus(8'h07 ^ 8'h00, 1'b1, s1);
    par_flip = 1'b0;
    idle(10);
    check_output("par_valid_count", valid_cyc_q.size(), 1);
    check_output("par_good_byte", q_int(0, 1), 32'h07);
    check_output("par_good_cycle", q_int(0, 0), exp_strobe_cyc(s0));
    check_output("par_err_count", err_cyc_q.size(), 1);
    check_output("par_err_cycle", q_int(0, 2), exp_strobe_cyc(s1));
    check_output("par_byte_kept", data_out, model_byte);
`endif

    // Random bytes with random gaps and an occasional bad stop bit
    clear_log();
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      apply_stimulus(d, good, s0);
      if (good) begin
        exp_cyc_q.push_back(exp_strobe_cyc(s0));
        exp_byte_q.push_back(d);
        model_byte = d;
        gap = $urandom_range(0, 12);
      end else begin
        exp_err_q.push_back(exp_strobe_cyc(s0));
        gap = $urandom_range(4, 12);
      end
      if (gap > 0) idle(gap);
    end
    idle(8);
    check_output("rand_valid_count", valid_cyc_q.size(), exp_cyc_q.size());
    check_output("rand_err_count", err_cyc_q.size(), exp_err_q.size());
    foreach (exp_cyc_q[i]) begin
      check_output($sformatf("rand_valid_cycle_%0d", i), q_int(i, 0), exp_cyc_q[i]);
      check_output($sformatf("rand_valid_byte_%0d", i), q_int(i, 1), 32'(exp_byte_q[i]));
    end
    foreach (exp_err_q[i]) begin
      check_output($sformatf("rand_err_cycle_%0d", i), q_int(i, 2), exp_err_q[i]);
    end
    check_output("rand_byte_held", data_out, model_byte);

    // Reset in the middle of data bit 4, then a fresh frame 0x81
    clear_log();
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_byte", data_out, 8'h00);
    check_output("midrst_busy", busy, 1'b0);
    model_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    rst_n = 1'b1;
    idle(20);
    check_output("midrst_no_strobe", valid_cyc_q.size() + err_cyc_q.size(), 0);
    apply_stimulus(8'h81, 1'b1, s0);
    model_byte = 8'h81;
    idle(4);
    check_output("midrst_valid_count", valid_cyc_q.size(), 1);
    check_output("midrst_valid_byte", q_int(0, 1), 32'h81);
    check_output("midrst_valid_cycle", q_int(0, 0), exp_strobe_cyc(s0));
    check_output("midrst_no_err", err_cyc_q.size(), 0);

    // Whole-run properties
    check_output("never_both_strobes", both_cnt, 0);
    check_output("byte_only_changes_on_valid", bad_change, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
